// File: rtl/axi_node_pkg.sv
// Shared AXI node types: default W beat layout and default W-order FIFO depth.
package axi_node_pkg;

   localparam int DEFAULT_FIFO_DEPTH = 8;
   localparam int DEFAULT_DATA_WIDTH = 64;
   localparam int DEFAULT_USER_WIDTH = 6;

   // Reference beat layout; modules re-declare it with their own widths and the
   // same field order so beats can be passed through a type parameter.
   typedef struct packed {
      logic [DEFAULT_DATA_WIDTH-1:0]   data;
      logic [DEFAULT_DATA_WIDTH/8-1:0] strb;
      logic                            last;
      logic [DEFAULT_USER_WIDTH-1:0]   user;
   } w_beat_t;

endpackage

// File: rtl/axi_w_mux_ordered_out_slice.sv
// One-entry elastic register slice for W beats; breaks the master-side valid/payload path.
module axi_w_out_slice
   import axi_node_pkg::*;
#(
   parameter type beat_t = w_beat_t
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  up_valid,
   output logic  up_ready,
   input  beat_t up_beat,
   output logic  dn_valid,
   input  logic  dn_ready,
   output beat_t dn_beat
);

   logic  valid_q;
   beat_t beat_q;

   // Accept a new beat whenever the slot is empty or being drained this cycle.
   assign up_ready = ~valid_q | dn_ready;
   assign dn_valid = valid_q;
   assign dn_beat  = beat_q;

   // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         beat_q  <= '0;
      end else if (up_ready) begin
         valid_q <= up_valid;
         if (up_valid) beat_q <= up_beat;
      end
   end

endmodule

// File: rtl/axi_w_mux_ordered.sv
// Ordered W multiplexer: forwards W bursts in AW grant order held in an ID FIFO.
// Define AXI_W_MUX_OUT_REG_EN to register the master W outputs through a slice.
module axi_w_mux_ordered
   import axi_node_pkg::*;
#(
   parameter int N_TARG_PORT = 8,
   parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
   parameter int DATA_WIDTH  = 64,
   parameter int USER_WIDTH  = 6
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    test_en_i,
   input  logic [N_TARG_PORT-1:0][DATA_WIDTH-1:0]   wdata_i,
   input  logic [N_TARG_PORT-1:0][DATA_WIDTH/8-1:0] wstrb_i,
   input  logic [N_TARG_PORT-1:0]                   wlast_i,
   input  logic [N_TARG_PORT-1:0][USER_WIDTH-1:0]   wuser_i,
   input  logic [N_TARG_PORT-1:0]                   wvalid_i,
   output logic [N_TARG_PORT-1:0]                   wready_o,
   output logic [DATA_WIDTH-1:0]                    wdata_o,
   output logic [DATA_WIDTH/8-1:0]                  wstrb_o,
   output logic                                     wlast_o,
   output logic [USER_WIDTH-1:0]                    wuser_o,
   output logic                                     wvalid_o,
   input  logic                                     wready_i,
   input  logic [N_TARG_PORT-1:0]                   ID_i,
   input  logic                                     push_ID_i,
   output logic                                     grant_FIFO_ID_o
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [STRB_WIDTH-1:0] strb;
      logic                  last;
      logic [USER_WIDTH-1:0] user;
   } beat_t;

   logic [N_TARG_PORT-1:0] id_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [CNT_W-1:0]       count;
   logic                   full;
   logic                   head_valid;
   logic [N_TARG_PORT-1:0] head;
   logic                   push;
   logic                   pop;
   logic                   wvalid_int;
   logic                   ready_int;
   beat_t                  beat_sel;
   logic                   test_en_unused;

   // The ID FIFO has no scan-specific behaviour; test mode is accepted and ignored.
   assign test_en_unused = test_en_i;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full            = (count == CNT_W'(FIFO_DEPTH));
   assign head_valid      = (count != '0);
   assign head            = head_valid ? id_mem[rd_ptr] : '0;
   assign push            = push_ID_i & ~full;
   assign pop             = head_valid & wvalid_int & ready_int & beat_sel.last;
   assign grant_FIFO_ID_o = ~full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // NOTE: ID storage is not reset; entries are only observed while count marks them valid.
   always_ff @(posedge clk) begin
      if (push) id_mem[wr_ptr] <= ID_i;
   end

   // NOTE: every always_comb output gets a default first, so no latch can be inferred.
   always_comb begin
      beat_sel   = '0;
      wvalid_int = 1'b0;
      for (int i = 0; i < N_TARG_PORT; i++) begin
         beat_sel.data = beat_sel.data | (wdata_i[i] & {DATA_WIDTH{head[i]}});
         beat_sel.strb = beat_sel.strb | (wstrb_i[i] & {STRB_WIDTH{head[i]}});
         beat_sel.last = beat_sel.last | (wlast_i[i] & head[i]);
         beat_sel.user = beat_sel.user | (wuser_i[i] & {USER_WIDTH{head[i]}});
         wvalid_int    = wvalid_int | (wvalid_i[i] & head[i]);
      end
   end

   assign wready_o = {N_TARG_PORT{ready_int & head_valid}} & head;

`ifdef AXI_W_MUX_OUT_REG_EN
   beat_t beat_out;

   axi_w_out_slice #(
      .beat_t (beat_t)
   ) u_out_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (wvalid_int),
      .up_ready (ready_int),
      .up_beat  (beat_sel),
      .dn_valid (wvalid_o),
      .dn_ready (wready_i),
      .dn_beat  (beat_out)
   );

   assign wdata_o = beat_out.data;
   assign wstrb_o = beat_out.strb;
   assign wlast_o = beat_out.last;
   assign wuser_o = beat_out.user;
`else
   assign ready_int = wready_i;
   assign wvalid_o  = wvalid_int;
   assign wdata_o   = beat_sel.data;
   assign wstrb_o   = beat_sel.strb;
   assign wlast_o   = beat_sel.last;
   assign wuser_o   = beat_sel.user;
`endif

endmodule
